// File: rtl/irq_ctrl_if.sv
// CPU-side bus and interrupt request/acknowledge bundle for irq_ctrl.
// master = CPU core, slave = interrupt controller.
interface irq_ctrl_if;
   logic [15:0] address;
   logic [7:0]  indata;
   logic [7:0]  outdata;
   logic        load;
   logic        store;
   logic        intreq;
   logic [15:0] intaddress;
   logic        intack;

   modport master (
      output address, indata, load, store, intack,
      input  outdata, intreq, intaddress
   );

   modport slave (
      input  address, indata, load, store, intack,
      output outdata, intreq, intaddress
   );
endinterface

// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt controller with IF/IE registers, latched vector and request/ack handshake.
// Optional macro IRQ_CTRL_EDGE_DETECT_EN: rising-edge source detection instead of level sensing.
module irq_ctrl #(
   parameter int          N_IRQ      = 5,
   parameter logic [15:0] IF_ADDR    = 16'hFF0F,
   parameter logic [15:0] IE_ADDR    = 16'hFFFF,
   parameter logic [15:0] VEC_BASE   = 16'h0040,
   parameter logic [15:0] VEC_STRIDE = 16'h0008
) (
   input  logic             clockgb,
   input  logic             resetn,
   irq_ctrl_if.slave        bus,
   input  logic [N_IRQ-1:0] interrupts,
   output logic [N_IRQ-1:0] dints,
   output logic             wake
);
   localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

   typedef enum logic {IDLE, PENDING} state_t;

   state_t           state_q, state_d;
   logic [N_IRQ-1:0] if_q, if_d, ie_q, ie_d;
   logic [N_IRQ-1:0] events, pend;
   logic [IDX_W-1:0] lat_idx_q, lat_idx_d, sel;
   logic             intreq_q, intreq_d;
   logic [15:0]      intaddr_q, intaddr_d, sel_vec;
   logic             if_wr, ie_wr, ack_clear;
   logic             unused_indata;

`ifdef IRQ_CTRL_EDGE_DETECT_EN
   logic [N_IRQ-1:0] prev_q;

   always_ff @(posedge clockgb or negedge resetn) begin
      if (!resetn) prev_q <= '0;
      else         prev_q <= interrupts;
   end

   assign events = interrupts & ~prev_q;
`else
   assign events = interrupts;
`endif

   assign if_wr         = bus.store && (bus.address == IF_ADDR);
   assign ie_wr         = bus.store && (bus.address == IE_ADDR);
   assign pend          = if_q & ie_q;
   assign wake          = |pend;
   assign dints         = if_q;
   assign unused_indata = ^bus.indata;

   // Lowest pending index wins; scan from the top so the last hit is the lowest.
   always_comb begin
      sel = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (pend[i]) sel = IDX_W'(i);
      end
   end

   assign sel_vec = VEC_BASE + 16'(sel) * VEC_STRIDE;

   always_comb begin
      state_d   = state_q;
      lat_idx_d = lat_idx_q;
      intreq_d  = intreq_q;
      intaddr_d = intaddr_q;
      ack_clear = 1'b0;
      case (state_q)
         IDLE: begin
            if (|pend) begin
               state_d   = PENDING;
               lat_idx_d = sel;
               intaddr_d = sel_vec;
               intreq_d  = 1'b1;
            end
         end
         PENDING: begin
            // A vanished request is a cancel even if the CPU acks in the same cycle.
            if (!pend[lat_idx_q]) begin
               state_d  = IDLE;
               intreq_d = 1'b0;
            end else if (bus.intack) begin
               ack_clear = 1'b1;
               state_d   = IDLE;
               intreq_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Source events are OR-ed in last so they beat both CPU writes and ack clears.
   always_comb begin
      if_d = if_q;
      if (if_wr) if_d = bus.indata[N_IRQ-1:0];
      if (ack_clear) if_d[lat_idx_q] = 1'b0;
      if_d = if_d | events;
   end

   assign ie_d = ie_wr ? bus.indata[N_IRQ-1:0] : ie_q;

   always_comb begin
      bus.outdata = 8'h00;
      if (bus.load && (bus.address == IF_ADDR)) begin
         bus.outdata              = 8'hFF;
         bus.outdata[N_IRQ-1:0]   = if_q;
      end else if (bus.load && (bus.address == IE_ADDR)) begin
         bus.outdata[N_IRQ-1:0]   = ie_q;
      end
   end

   always_ff @(posedge clockgb or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         if_q      <= '0;
         ie_q      <= '0;
         lat_idx_q <= '0;
         intreq_q  <= 1'b0;
         intaddr_q <= 16'h0000;
      end else begin
         state_q   <= state_d;
         if_q      <= if_d;
         ie_q      <= ie_d;
         lat_idx_q <= lat_idx_d;
         intreq_q  <= intreq_d;
         intaddr_q <= intaddr_d;
      end
   end

   assign bus.intreq     = intreq_q;
   assign bus.intaddress = intaddr_q;
endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus randomized traffic against a behavioural model.
// Honours IRQ_CTRL_EDGE_DETECT_EN in the model when the design is built with it.
module tb_irq_ctrl;
   localparam int          N    = 5;
   localparam logic [15:0] IF_A = 16'hFF0F;
   localparam logic [15:0] IE_A = 16'hFFFF;
   localparam logic [15:0] VB   = 16'h0040;
   localparam logic [15:0] VS   = 16'h0008;
   localparam bit [7:0]    MASK = 8'((1 << N) - 1);

   logic         clockgb = 1'b0;
   logic         resetn  = 1'b0;
   logic [N-1:0] interrupts, dints;
   logic         wake;
   logic [7:0]   ints8, dints8;
   logic         wake8;

   irq_ctrl_if bus();
   irq_ctrl_if bus8();

   irq_ctrl #(.N_IRQ(N), .IF_ADDR(IF_A), .IE_ADDR(IE_A), .VEC_BASE(VB), .VEC_STRIDE(VS)) u_dut (
      .clockgb(clockgb), .resetn(resetn), .bus(bus),
      .interrupts(interrupts), .dints(dints), .wake(wake)
   );

   irq_ctrl #(.N_IRQ(8), .IF_ADDR(IF_A), .IE_ADDR(IE_A), .VEC_BASE(16'hFFF8), .VEC_STRIDE(16'h0004)) u_dut8 (
      .clockgb(clockgb), .resetn(resetn), .bus(bus8),
      .interrupts(ints8), .dints(dints8), .wake(wake8)
   );

   always #5 clockgb = ~clockgb;

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;

   // Model: flags and enables as bytes, latched channel as an int (-1 = no request).
   bit [7:0]  m_if, m_ie, m_prev;
   int        m_lat;
   bit [15:0] m_vec;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_if   = 8'h00;
      m_ie   = 8'h00;
      m_prev = 8'h00;
      m_lat  = -1;
      m_vec  = 16'h0000;
   endtask

   task automatic model_step();
      bit [7:0] ev, pend, nif, src;
      if (!resetn) begin
         model_reset();
         return;
      end
      src = 8'(interrupts);
`ifdef IRQ_CTRL_EDGE_DETECT_EN
      ev = src & ~m_prev;
`else
      ev = src;
`endif
      pend = m_if & m_ie;
      nif  = m_if;
      if (bus.store && bus.address == IF_A) nif = bus.indata & MASK;
      if (m_lat >= 0) begin
         if (!pend[m_lat]) m_lat = -1;
         else if (bus.intack) begin
            nif[m_lat] = 1'b0;
            m_lat      = -1;
         end
      end else if (pend != 8'h00) begin
         for (int i = 0; i < N; i++) begin
            if (pend[i]) begin
               m_lat = i;
               break;
            end
         end
         m_vec = 16'((int'(VB) + m_lat * int'(VS)) & 32'hFFFF);
      end
      if (bus.store && bus.address == IE_A) m_ie = bus.indata & MASK;
      m_if   = nif | ev;
      m_prev = src;
   endtask

   function automatic bit [7:0] exp_rd();
      if (bus.load && bus.address == IF_A) return m_if | ~MASK;
      if (bus.load && bus.address == IE_A) return m_ie;
      return 8'h00;
   endfunction

   always @(negedge resetn) model_reset();

   always @(negedge clockgb) begin
      if (cmp_en) begin
         check("intreq", 32'(bus.intreq), 32'(m_lat >= 0));
         if (m_lat >= 0) check("intaddress", 32'(bus.intaddress), 32'(m_vec));
         check("dints", 32'(dints), 32'(m_if & MASK));
         check("wake", 32'(wake), 32'(|(m_if & m_ie)));
         check("outdata", 32'(bus.outdata), 32'(exp_rd()));
      end
   end

   task automatic tick();
      @(posedge clockgb);
      model_step();
      #1;
   endtask

   task automatic idle_bus();
      bus.address = 16'h0000;
      bus.indata  = 8'h00;
      bus.load    = 1'b0;
      bus.store   = 1'b0;
      bus.intack  = 1'b0;
      interrupts  = '0;
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      bus.store   = 1'b1;
      bus.address = a;
      bus.indata  = d;
      tick();
      bus.store   = 1'b0;
   endtask

   task automatic pulse(input logic [N-1:0] p);
      interrupts = p;
      tick();
      interrupts = '0;
   endtask

   task automatic ack();
      bus.intack = 1'b1;
      tick();
      bus.intack = 1'b0;
   endtask

   initial begin
      int  reqs;
      bit  last;
      bit [3:0] r;
      idle_bus();
      bus8.address = 16'h0000; bus8.indata = 8'h00; bus8.load = 1'b0;
      bus8.store = 1'b0; bus8.intack = 1'b0; ints8 = 8'h00;
      model_reset();
      #1 cmp_en = 1'b1;
      repeat (3) tick();
      check("rst_intreq", 32'(bus.intreq), 0);
      check("rst_intaddress", 32'(bus.intaddress), 0);
      check("rst_dints", 32'(dints), 0);
      check("rst_wake", 32'(wake), 0);
      check("rst8_intreq", 32'(bus8.intreq), 0);
      resetn = 1'b1;
      tick();

      // Single pulse on channel 2.
      wr(IE_A, 8'h1F);
      pulse(5'b00100);
      check("t1_if", 32'(dints), 32'h04);
      check("t1_req_early", 32'(bus.intreq), 0);
      tick();
      check("t1_req", 32'(bus.intreq), 1);
      check("t1_vec", 32'(bus.intaddress), 32'h0050);
      ack();
      check("t1_if_clr", 32'(dints), 0);
      check("t1_req_drop", 32'(bus.intreq), 0);

      // Vector stays frozen when a higher priority arrives mid-handshake.
      pulse(5'b10000);
      tick();
      check("t2_vec4", 32'(bus.intaddress), 32'h0060);
      pulse(5'b00001);
      check("t2_frozen", 32'(bus.intaddress), 32'h0060);
      check("t2_if", 32'(dints), 32'h11);
      ack();
      check("t2_req_drop", 32'(bus.intreq), 0);
      tick();
      check("t2_req0", 32'(bus.intreq), 1);
      check("t2_vec0", 32'(bus.intaddress), 32'h0040);
      ack();
      check("t2_if_clr", 32'(dints), 0);

      // CPU clears IF while pending: request is cancelled without ack.
      pulse(5'b00010);
      tick();
      check("t3_vec1", 32'(bus.intaddress), 32'h0048);
      wr(IF_A, 8'h00);
      tick();
      check("t3_cancel", 32'(bus.intreq), 0);
      tick();
      check("t3_stay_idle", 32'(bus.intreq), 0);

      // Masked source: visible in IF, wakes only once enabled.
      wr(IE_A, 8'h00);
      pulse(5'b01000);
      tick();
      check("t4_wake0", 32'(wake), 0);
      check("t4_req0", 32'(bus.intreq), 0);
      bus.load = 1'b1; bus.address = IF_A;
      #1 check("t4_read_if", 32'(bus.outdata), 32'hE8);
      bus.load = 1'b0;
      wr(IE_A, 8'h08);
      check("t4_wake1", 32'(wake), 1);
      tick();
      check("t4_req1", 32'(bus.intreq), 1);
      check("t4_vec3", 32'(bus.intaddress), 32'h0058);
      ack();
      wr(IE_A, 8'h1F);

      // Ack and fresh event on the same channel in the same cycle: set wins.
      pulse(5'b00100);
      tick();
      bus.intack = 1'b1;
      pulse(5'b00100);
      bus.intack = 1'b0;
      check("t5_if_kept", 32'(dints), 32'h04);
      check("t5_req_gap", 32'(bus.intreq), 0);
      tick();
      check("t5_req_again", 32'(bus.intreq), 1);
      check("t5_vec", 32'(bus.intaddress), 32'h0050);
      ack();

      // Source held high for 10 cycles, acknowledged once.
      interrupts = 5'b00001;
      reqs = 0; last = 1'b0;
      for (int i = 0; i < 10; i++) begin
         bus.intack = (i == 2);
         tick();
         if (bus.intreq && !last) reqs++;
         last = bus.intreq;
      end
      bus.intack = 1'b0;
      interrupts = '0;
      tick();
`ifdef IRQ_CTRL_EDGE_DETECT_EN
      check("held_reqs", 32'(reqs), 1);
      check("held_if", 32'(dints), 0);
      check("held_req", 32'(bus.intreq), 0);
`else
      check("held_reqs", 32'(reqs), 2);
      check("held_if", 32'(dints), 32'h01);
      check("held_req", 32'(bus.intreq), 1);
`endif
      ack();
      check("held_final_if", 32'(dints), 0);

      // Asynchronous reset while a request is outstanding.
      pulse(5'b01000);
      tick();
      check("rstp_req", 32'(bus.intreq), 1);
      #3 resetn = 1'b0;
      #1;
      check("rstp_intreq", 32'(bus.intreq), 0);
      check("rstp_intaddress", 32'(bus.intaddress), 0);
      check("rstp_dints", 32'(dints), 0);
      check("rstp_wake", 32'(wake), 0);
      bus.load = 1'b1; bus.address = IE_A;
      #1 check("rstp_ie", 32'(bus.outdata), 0);
      bus.load = 1'b0;
      tick();
      resetn = 1'b1;
      tick();
      wr(IE_A, 8'h1F);

      // Randomized traffic, checked every cycle by the compare process.
      for (int c = 0; c < 1500; c++) begin
         r = 4'($urandom_range(0, 15));
         bus.load  = r[0];
         bus.store = (r[3:1] == 3'b000);
         case ($urandom_range(0, 2))
            0:       bus.address = IF_A;
            1:       bus.address = IE_A;
            default: bus.address = 16'($urandom);
         endcase
         bus.indata = 8'($urandom);
         for (int b = 0; b < N; b++) interrupts[b] = ($urandom_range(0, 5) == 0);
         bus.intack = bus.intreq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
         tick();
      end
      idle_bus();
      tick();

      // Eight channels with a wrapping vector table.
      bus8.store = 1'b1; bus8.address = IE_A; bus8.indata = 8'hFF;
      tick();
      bus8.store = 1'b0;
      ints8 = 8'h80;
      tick();
      ints8 = 8'h00;
      check("n8_if", 32'(dints8), 32'h80);
      tick();
      check("n8_req", 32'(bus8.intreq), 1);
      check("n8_vec_wrap", 32'(bus8.intaddress), 32'h0014);
      bus8.load = 1'b1; bus8.address = IF_A;
      #1 check("n8_read_if", 32'(bus8.outdata), 32'h80);
      bus8.load = 1'b0;
      tick();

      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
